// File: rtl/demux8_1x2_reg.sv
// demux8_1x2_reg: registered 1-to-2 demux with static or round-robin routing,
// valid/ready handshakes, one-entry holding register and wrapping counter per output.
module demux8_1x2_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             alt,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CW-1:0]    count1,
    output logic [CW-1:0]    count2
);
    logic rr;
    logic to1;
    logic free1;
    logic free2;
    logic acc;
    logic ld1;
    logic ld2;
    logic hs1;
    logic hs2;

    always_comb begin
        to1      = alt ? ~rr : sel;
        free1    = ~out1_valid | out1_ready;
        free2    = ~out2_valid | out2_ready;
        in_ready = to1 ? free1 : free2;
        acc      = in_valid & in_ready;
        ld1      = acc & to1;
        ld2      = acc & ~to1;
        hs1      = out1_valid & out1_ready;
        hs2      = out2_valid & out2_ready;
    end

    // A load overrides the drain, so a full channel with a ready consumer refills with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1       <= '0;
            out2       <= '0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
            count1     <= '0;
            count2     <= '0;
            rr         <= 1'b0;
        end else begin
            if (ld1) out1 <= in;
            if (ld2) out2 <= in;
            out1_valid <= ld1 | (out1_valid & ~out1_ready);
            out2_valid <= ld2 | (out2_valid & ~out2_ready);
            count1     <= count1 + CW'(hs1);
            count2     <= count2 + CW'(hs2);
            rr         <= alt ? rr ^ acc : 1'b0;
        end
    end
endmodule
